// File: rtl/viterbi_stream_decoder.sv
// Framed rate-1/2 Viterbi decoder: buffers a frame, runs ACS one step per cycle, traces back,
// then streams decoded bits. Define VITERBI_SOFT_EN for 3-bit soft-decision symbol values.
module viterbi_stream_decoder #(
    parameter int unsigned  K         = 3,
    parameter logic [K-1:0] G0        = 3'b111,
    parameter logic [K-1:0] G1        = 3'b101,
    parameter int unsigned  MAX_FRAME = 32,
    parameter int unsigned  PMW       = 8,
`ifdef VITERBI_SOFT_EN
    localparam int unsigned SW        = 3
`else
    localparam int unsigned SW        = 1
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*SW-1:0] in_sym,
    input  logic            in_last,
    input  logic            in_term,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_bit,
    output logic            out_last,
    output logic            busy,
    output logic            overflow,
    output logic            len_err
);
    localparam int unsigned M   = K - 1;
    localparam int unsigned S   = 1 << M;
    localparam int unsigned AW  = $clog2(MAX_FRAME);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned BMW = SW + 1;
    localparam int unsigned PW1 = PMW + 1;
    localparam logic [PMW-1:0] PM_INIT = {2'b01, {(PMW-2){1'b0}}};

    typedef enum logic [2:0] {IDLE, RX, ACS, BEST, TRACE, OUT} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q, len_q, out_len;
    logic            term_q;
    logic [AW-1:0]   t_q, idx_q;
    logic [M-1:0]    s_q, best_d;
    logic [PMW-1:0]  pm_q [S];
    logic [PMW-1:0]  pm_d [S];
    logic [S-1:0]    surv_d;
    logic [2*SW-1:0] sym_buf_q [MAX_FRAME];
    logic [S-1:0]    surv_q    [MAX_FRAME];
    logic [MAX_FRAME-1:0] out_buf_q;
    logic            in_ready_q, out_valid_q, out_bit_q, out_last_q, busy_q, overflow_q, len_err_q;
    logic            in_fire;

    assign in_fire = in_valid & in_ready_q;
    assign out_len = term_q ? len_q - CW'(M) : len_q;

    function automatic logic [PMW-1:0] pm_init(input int unsigned n);
        return (n == 0) ? '0 : PM_INIT;
    endfunction

    // Distance between the received symbol and the code bits of transition r = {pred, b}
    function automatic logic [BMW-1:0] branch_metric(input logic [K-1:0] r, input logic [2*SW-1:0] y);
        logic e0, e1;
        e0 = ^(r & G0);
        e1 = ^(r & G1);
`ifdef VITERBI_SOFT_EN
        return BMW'(e0 ? 3'd7 - y[5:3] : y[5:3]) + BMW'(e1 ? 3'd7 - y[2:0] : y[2:0]);
`else
        return BMW'(e0 ^ y[1]) + BMW'(e1 ^ y[0]);
`endif
    endfunction

    // Add-compare-select for all states of step t_q, with saturation and MSB normalisation
    always_comb begin
        logic [M-1:0]   p0, p1;
        logic [PMW:0]   c0, c1;
        logic [PMW-1:0] m0, m1;
        logic           all_msb;
        surv_d  = '0;
        all_msb = 1'b1;
        for (int n = 0; n < S; n++) begin
            p0 = M'(n >> 1);
            p1 = p0 | {1'b1, {(M-1){1'b0}}};
            c0 = {1'b0, pm_q[p0]} + PW1'(branch_metric({1'b0, M'(n)}, sym_buf_q[t_q]));
            c1 = {1'b0, pm_q[p1]} + PW1'(branch_metric({1'b1, M'(n)}, sym_buf_q[t_q]));
            m0 = c0[PMW] ? '1 : c0[PMW-1:0];
            m1 = c1[PMW] ? '1 : c1[PMW-1:0];
            surv_d[n] = (m1 < m0);
            pm_d[n]   = (m1 < m0) ? m1 : m0;
            all_msb   = all_msb & pm_d[n][PMW-1];
        end
        if (all_msb) begin
            for (int n = 0; n < S; n++) pm_d[n][PMW-1] = 1'b0;
        end
    end

    always_comb begin
        logic [PMW-1:0] best_pm;
        best_d  = '0;
        best_pm = pm_q[0];
        for (int n = 1; n < S; n++) begin
            if (pm_q[n] < best_pm) begin
                best_pm = pm_q[n];
                best_d  = M'(n);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire && cnt_q != CW'(MAX_FRAME)) sym_buf_q[AW'(cnt_q)] <= in_sym;
        if (state_q == ACS)   surv_q[t_q]    <= surv_d;
        if (state_q == TRACE) out_buf_q[t_q] <= s_q[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            term_q      <= 1'b0;
            t_q         <= '0;
            idx_q       <= '0;
            s_q         <= '0;
            for (int n = 0; n < S; n++) pm_q[n] <= pm_init(n);
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            len_err_q <= 1'b0;
            case (state_q)
                IDLE, RX: begin
                    if (in_fire) begin
                        if (state_q == IDLE)               overflow_q <= 1'b0;
                        else if (cnt_q == CW'(MAX_FRAME))  overflow_q <= 1'b1;
                        if (cnt_q != CW'(MAX_FRAME)) cnt_q <= cnt_q + CW'(1);
                        if (in_last) begin
                            len_q      <= (cnt_q == CW'(MAX_FRAME)) ? cnt_q : cnt_q + CW'(1);
                            term_q     <= in_term;
                            cnt_q      <= '0;
                            t_q        <= '0;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                            state_q    <= ACS;
                        end else begin
                            state_q <= RX;
                        end
                    end
                end
                ACS: begin
                    pm_q <= pm_d;
                    if (t_q == AW'(len_q - CW'(1))) begin
                        len_err_q <= term_q && (len_q <= CW'(M));
                        state_q   <= BEST;
                    end else begin
                        t_q <= t_q + AW'(1);
                    end
                end
                BEST: begin
                    if (term_q && (len_q <= CW'(M))) begin
                        for (int n = 0; n < S; n++) pm_q[n] <= pm_init(n);
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        s_q     <= term_q ? '0 : best_d;
                        t_q     <= AW'(len_q - CW'(1));
                        state_q <= TRACE;
                    end
                end
                TRACE: begin
                    s_q <= {surv_q[t_q][s_q], s_q[M-1:1]};
                    if (t_q == '0) begin
                        out_valid_q <= 1'b1;
                        out_bit_q   <= s_q[0];
                        out_last_q  <= (out_len == CW'(1));
                        idx_q       <= '0;
                        busy_q      <= 1'b0;
                        state_q     <= OUT;
                    end else begin
                        t_q <= t_q - AW'(1);
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        if (out_last_q) begin
                            for (int n = 0; n < S; n++) pm_q[n] <= pm_init(n);
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            in_ready_q  <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            idx_q      <= idx_q + AW'(1);
                            out_bit_q  <= out_buf_q[idx_q + AW'(1)];
                            out_last_q <= (CW'(idx_q) + CW'(2) == out_len);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign overflow  = overflow_q;
    assign len_err   = len_err_q;
endmodule

// File: tb/tb_viterbi_stream_decoder.sv
// Bench for viterbi_stream_decoder: encodes known bit streams with a reference encoder and
// expects the decoder to recover them, plus literal vectors, overflow, length error and reset.
`timescale 1ns/1ps
module tb_viterbi_stream_decoder;
    localparam int MAX_FRAME = 32;
`ifdef VITERBI_SOFT_EN
    localparam int SW = 3;
`else
    localparam int SW = 1;
`endif
    typedef logic [2*SW-1:0] sym_t;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, in_last, in_term, out_valid, out_ready, out_bit, out_last;
    logic busy, overflow, len_err;
    sym_t in_sym;

    viterbi_stream_decoder #(.K(3), .G0(3'b111), .G1(3'b101), .MAX_FRAME(MAX_FRAME), .PMW(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym),
        .in_last(in_last), .in_term(in_term), .out_valid(out_valid), .out_ready(out_ready),
        .out_bit(out_bit), .out_last(out_last), .busy(busy), .overflow(overflow), .len_err(len_err));

    always #5 clk = ~clk;

    int   total = 0, bad = 0, cyc = 0, c0 = 0, exp_lat = 0, rdy_k = 0;
    bit   lat_pending = 0, rdy_toggle = 0, stall_prev = 0, pbit, plast, e;
    bit   exp_q[$];
    bit   src[$];
    logic [1:0] hsyms[$];
    sym_t syms[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (!rdy_toggle) out_ready = 1'b1;
        else begin
            out_ready = (rdy_k % 4 == 0) || (rdy_k % 4 == 3);
            rdy_k++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic sym_t mk_sym(input logic [1:0] h);
`ifdef VITERBI_SOFT_EN
        return {h[1] ? 3'd7 : 3'd0, h[0] ? 3'd7 : 3'd0};
`else
        return h;
`endif
    endfunction

    // Reference encoder: state holds the last two bits, newest in bit 0
    task automatic encode_src();
        logic [1:0] st;
        logic [2:0] r;
        st = 2'b00;
        hsyms.delete();
        syms.delete();
        foreach (src[i]) begin
            r = {st, src[i]};
            hsyms.push_back({^(r & 3'b111), ^(r & 3'b101)});
            syms.push_back(mk_sym(hsyms[i]));
            st = {st[0], src[i]};
        end
    endtask

    // Compare process: checks every accepted bit against the scoreboard and stall stability
    always @(negedge clk) begin
        if (rst) stall_prev = 0;
        else begin
            if (stall_prev) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_bit", out_bit, pbit);
                chk("hold_last", out_last, plast);
            end
            if (out_valid && lat_pending) begin
                chk("first_valid_latency", cyc - c0, exp_lat);
                lat_pending = 0;
            end
            if (out_valid && exp_q.size() == 0) chk("spurious_out_valid", out_valid, 0);
            else if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                chk("out_bit", out_bit, e);
                chk("out_last", out_last, exp_q.size() == 0);
            end
            stall_prev = out_valid && !out_ready;
            pbit  = out_bit;
            plast = out_last;
        end
    end

    task automatic push(input sym_t s, input bit last, input bit term);
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b1; in_sym = s; in_last = last; in_term = term;
        while (!in_ready && guard < 500) begin @(negedge clk); guard++; end
        if (!in_ready) chk("in_ready_timeout", in_ready, 1);
        if (last) c0 = cyc;
        @(posedge clk);
        #1 in_valid = 1'b0; in_last = 1'b0; in_term = 1'b0;
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 3000) begin @(negedge clk); guard++; end
        chk("drain_remaining", exp_q.size(), 0);
        @(negedge clk);
        chk("in_ready_after_frame", in_ready, 1);
        chk("busy_after_frame", busy, 0);
    endtask

    task automatic run_frame(input bit term, input bit clr_chk);
        int n = syms.size();
        exp_lat = 2 * ((n > MAX_FRAME) ? MAX_FRAME : n) + 2;
        lat_pending = 1;
        foreach (syms[i]) begin
            push(syms[i], i == n - 1, term);
            if (clr_chk && i == 0) begin @(negedge clk); chk("overflow_clear", overflow, 0); end
        end
        wait_drain();
    endtask

    initial begin
        logic [1:0] lit[6];
        rst = 1'b1; in_valid = 1'b0; in_sym = '0; in_last = 1'b0; in_term = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_len_err", len_err, 0);

        // Terminated frame 1,0,1,1 + tail; pins the encoder against the literal symbols
        src = '{1, 0, 1, 1, 0, 0};
        encode_src();
        lit = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        for (int i = 0; i < 6; i++) chk("enc_model", hsyms[i], lit[i]);
`ifdef VITERBI_SOFT_EN
        syms = '{{3'd7, 3'd7}, {3'd6, 3'd1}, {3'd0, 3'd2}, {3'd1, 3'd6}, {3'd0, 3'd7}, {3'd7, 3'd6}};
`endif
        exp_q = '{1, 0, 1, 1};
        run_frame(1'b1, 1'b0);

        // Same frame with the third symbol corrupted to 10
        encode_src();
        syms[2] = mk_sym(2'b10);
        exp_q = '{1, 0, 1, 1};
        run_frame(1'b1, 1'b0);

        // Non-terminated 11,10,00,01
        src = '{1, 0, 1, 1};
        encode_src();
        exp_q = '{1, 0, 1, 1};
        run_frame(1'b0, 1'b0);

        // Sink stalls with ready pattern 1,0,0,1
        src = '{1, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1, 0};
        encode_src();
        exp_q = src;
        rdy_k = 0; rdy_toggle = 1;
        run_frame(1'b0, 1'b0);
        rdy_toggle = 0;

        // 40 symbols into a 32-deep frame: only the first 32 decode
        src.delete();
        for (int i = 0; i < 40; i++) src.push_back(((i * 5 + 1) % 7) < 3);
        encode_src();
        exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back(src[i]);
        run_frame(1'b0, 1'b0);
        chk("overflow_sticky", overflow, 1);

        // Terminated overflow frame: stored part ends in state 0, 30 bits out
        src[30] = 0; src[31] = 0;
        encode_src();
        exp_q.delete();
        for (int i = 0; i < 30; i++) exp_q.push_back(src[i]);
        run_frame(1'b1, 1'b1);
        chk("overflow_again", overflow, 1);

        // Terminated frame of length 2 is too short
        src = '{1, 0};
        encode_src();
        lat_pending = 0;
        push(syms[0], 1'b0, 1'b1);
        push(syms[1], 1'b1, 1'b1);
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            chk($sformatf("len_err_cycle%0d", j), len_err, j == 3);
        end
        chk("len_err_in_ready", in_ready, 1);

        // Single-symbol non-terminated frame
        src = '{1};
        encode_src();
        exp_q = '{1};
        run_frame(1'b0, 1'b0);

        // Reset in the middle of traceback discards the frame
        src = '{0, 1, 1, 0, 0, 0};
        encode_src();
        lat_pending = 0;
        foreach (syms[i]) push(syms[i], i == 5, 1'b1);
        repeat (9) @(negedge clk);
        chk("busy_in_trace", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_in_ready", in_ready, 1);
        chk("rst_mid_busy", busy, 0);
        rst = 1'b0;

        // Decoder still correct after the mid-frame reset
        src = '{1, 0, 1, 1};
        encode_src();
        exp_q = '{1, 0, 1, 1};
        run_frame(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/viterbi_stream_decoder.md
# viterbi_stream_decoder

Parametrised hard/soft-decision Viterbi decoder for rate-1/2 feedforward convolutional codes with configurable constraint length, generator polynomials, frame depth and metric width. It sits between the symbol demodulator and the bit sink in the same receive path as the fixed K=3 decoder it supersedes. It adds ready/valid streaming on both sides, `in_last` framing, zero-tail terminated frames, path-metric normalisation and overflow reporting. Frames are buffered, run through ACS at one trellis step per cycle, traced back, and streamed out in order.

## Interface
- `K`, default 3: constraint length, legal 3..6; `M=K-1`; `S=2^M` states.
- `G0`, default 3'b111: generator 0, `K` bits.
- `G1`, default 3'b101: generator 1, `K` bits.
- `MAX_FRAME`, default 32: max symbols per frame, power of two, 4..256.
- `PMW`, default 8: path-metric width, at least 6.
- `SW` (derived): 3 if `VITERBI_SOFT_EN` is defined, else 1.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: symbol valid.
- `in_ready` out 1: decoder accepts a symbol.
- `in_sym` in 2*SW: `[2SW-1:SW]` is the G0 value; `[SW-1:0]` is the G1 value.
- `in_last` in 1: last symbol of frame; qualified by the handshake.
- `in_term` in 1: frame is zero-tail terminated; sampled with `in_last`.
- `out_valid` out 1: decoded bit valid.
- `out_ready` in 1: sink accepts the bit.
- `out_bit` out 1: decoded bit.
- `out_last` out 1: last decoded bit of frame.
- `busy` out 1: high in ACS, BEST or TRACE.
- `overflow` out 1: sticky; symbols were dropped in the current frame.
- `len_err` out 1: one-cycle pulse when a terminated frame has length ≤ M.

## Operation
- States: IDLE, RX, ACS, BEST, TRACE, OUT.
- Reset: state IDLE; all outputs 0 except `in_ready`=1; PM[0]=0; all other PMs = 2^(PMW-2); counters 0.
- Trellis convention: a state holds the last M input bits, `s[0]` newest. Next state = `{s[M-2:0], b}`. Expected symbol = `{^(r&G0), ^(r&G1)}` with `r={s,b}`.
- Predecessors of state `n`: `p_x={x, n[M-1:1]}`. The survivor bit is `x`. Ties select `x=0`, i.e. `x=1` is chosen only if strictly smaller.
- IDLE/RX: `in_ready`=1. Each handshake writes `sym_buf[cnt]` and increments `cnt`.
  - If `cnt==MAX_FRAME`, the symbol is dropped and `overflow` is set.
  - A handshake with `in_last` latches `L=min(cnt+1, MAX_FRAME)` and `term`, then goes to ACS.
  - An accept in IDLE moves to RX and clears `overflow`.
- ACS: step t=0..L-1, one step per cycle, all S states in parallel.
  - Branch metric is the Hamming distance (hard) or soft distance (see Configuration).
  - New PMs are written to the ping-pong bank; survivor bits go to `surv[t*S + n]`.
  - Normalisation: if every new PM has its MSB set, clear the MSB of all of them in the same cycle.
  - PM addition saturates at 2^PMW-1.
- BEST: start state is 0 if `term`, else the lowest-index state with minimal PM.
  - If `term` and L≤M: pulse `len_err`, go to IDLE, output nothing.
- TRACE: t=L-1 down to 0. Write `s[0]` to `out_buf[t]`, then `s <= {surv[t*S+s], s[M-1:1]}`.
- OUT: output length `N = term ? L-M : L`.
  - `out_bit = out_buf[idx]`; `out_last = (idx==N-1)`.
  - `idx` advances on `out_valid & out_ready`.
  - After the last handshake, go to IDLE; PMs reinitialise on that transition.
- `in_ready`=0 in ACS, BEST, TRACE and OUT. No back-to-back frame overlap.
- `rst` asserted in any state returns to reset values in the next cycle. A partial frame or output is discarded.

## Timing
- The `in_last` handshake occurs at cycle 0. ACS runs in cycles 1..L, BEST at L+1, TRACE at L+2..2L+1.
- First `out_valid` is at cycle 2L+2. With `out_ready` held high, bits stream one per cycle.
- `out_valid` is held, with `out_bit` and `out_last` stable, until accepted.
- `in_ready` returns to 1 in the cycle after the final output handshake.
- Single-symbol frame (L=1, non-terminated) is legal: one output bit.

## Configuration
- `VITERBI_SOFT_EN` defined: SW=3; each value 0..7, 0 = strong 0, 7 = strong 1.
  - Branch metric = Σ (e ? 7-v : v) over both values, range 0..14.
- Not defined: SW=1; branch metric = Hamming distance, 0..2.
- In both modes the symbol buffer holds `MAX_FRAME*2*SW` bits.

## Test plan
- Hard, K=3, G=7/5, `in_term`=1: symbols 11,10,00,01,01,11 → `out_bit` 1,0,1,1; `out_last` on the 4th; first `out_valid` 14 cycles after `in_last`.
- Same frame with the 3rd symbol corrupted to 10 → still 1,0,1,1. Non-terminated 4-symbol frame 11,10,00,01 → 1,0,1,1.
- Overflow, MAX_FRAME=32: 40 symbols, `in_last` on the 40th → `overflow`=1, 32 bits out (30 if terminated). `overflow` clears on the next frame's first accept.
- `in_term`=1 with L=2 → `len_err` pulse at cycle 3, no `out_valid`, `in_ready`=1 next cycle.
- `out_ready` toggling 1,0,0,1 → each bit held while stalled, no loss or duplication.
- Soft build: frame 1 with values (7,7)(6,1)(0,2)(1,6)(0,7)(7,6) → 1,0,1,1. A 200-symbol all-zero frame → no PM saturation; decode is all zeros. `rst` asserted mid-TRACE → IDLE, `out_valid`=0 the next cycle.
